// File: rtl/aes_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, with on-chip key expansion.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// The sender holds its data stable while valid is high and ready is low; the DUT does
// not retract out_valid before out_ready, and in_ready may depend on key_load.
module aes_dec_iter #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BLOCK_LENGTH-1:0] KEY,
    input  logic                    key_load,
    output logic                    key_ready,
    input  logic [BLOCK_LENGTH-1:0] IN,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [BLOCK_LENGTH-1:0] OUT,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              o_dbg_state
);

    typedef enum logic [2:0] {S_NOKEY, S_KEYEXP, S_READY, S_DEC, S_HOLD} state_t;

    state_t                  r_fsm, w_fsm_nxt;
    logic [BLOCK_LENGTH-1:0] r_rk [0:10];
    logic [BLOCK_LENGTH-1:0] r_data;
    logic [3:0]              r_rcount;
    logic                    w_load, w_accept;
    logic [3:0]              w_prev_idx;
    logic [BLOCK_LENGTH-1:0] w_exp_rk, w_isr, w_round;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, t;
        r = 8'h01;
        t = a;
        for (int i = 1; i < 8; i++) begin
            t = gf_mul(t, t);
            r = gf_mul(r, t);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] v;
        v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(v);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] w, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {w[23:0], w[31:24]};
        t   = {sbox(rot[31:24]) ^ rc, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w[127:96] ^ t;
        n1  = w[95:64] ^ n0;
        n2  = w[63:32] ^ n1;
        n3  = w[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte b = row + 4*col sits at bits [127-8b -: 8]; rows rotate right by their index.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = r + 4 * ((c - r + 4) % 4);
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*src -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    // Index guard keeps the previous-key lookup inside rk[0..10] when rcount is 0.
    assign w_prev_idx = (r_rcount == 4'd0) ? 4'd0 : r_rcount - 4'd1;
    assign w_exp_rk   = key_expand(r_rk[w_prev_idx], rcon(r_rcount));
    assign w_isr      = inv_shift_sub(r_data) ^ r_rk[r_rcount];
    assign w_round    = (r_rcount == 4'd0) ? w_isr : inv_mix(w_isr);
    assign o_dbg_state = r_fsm;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) r_fsm <= S_NOKEY;
        else      r_fsm <= w_fsm_nxt;
    end

    // Next-state decode and handshake outputs; key_load wins over in_valid in READY.
    always_comb begin
        w_fsm_nxt = r_fsm;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        OUT       = '0;
        w_load    = 1'b0;
        w_accept  = 1'b0;
        case (r_fsm)
            S_NOKEY: begin
                w_load = key_load;
                if (key_load) w_fsm_nxt = S_KEYEXP;
            end
            S_KEYEXP: begin
                if (r_rcount == 4'd10) w_fsm_nxt = S_READY;
            end
            S_READY: begin
                key_ready = 1'b1;
                in_ready  = !key_load;
                w_load    = key_load;
                w_accept  = !key_load && in_valid;
                if (key_load)      w_fsm_nxt = S_KEYEXP;
                else if (in_valid) w_fsm_nxt = S_DEC;
            end
            S_DEC: begin
                key_ready = 1'b1;
                if (r_rcount == 4'd0) w_fsm_nxt = S_HOLD;
            end
            S_HOLD: begin
                key_ready = 1'b1;
                out_valid = 1'b1;
                OUT       = r_data;
                if (out_ready) w_fsm_nxt = S_READY;
            end
            default: w_fsm_nxt = S_NOKEY;
        endcase
    end

    // Round-key file, round counter and block state; round keys change only during expansion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 11; i++) r_rk[i] <= '0;
            r_data   <= '0;
            r_rcount <= 4'd0;
        end else begin
            case (r_fsm)
                S_NOKEY, S_READY: begin
                    if (w_load) begin
                        r_rk[0]  <= KEY;
                        r_rcount <= 4'd1;
                    end else if (w_accept) begin
                        r_data   <= IN ^ r_rk[10];
                        r_rcount <= 4'd9;
                    end
                end
                S_KEYEXP: begin
                    r_rk[r_rcount] <= w_exp_rk;
                    r_rcount       <= (r_rcount == 4'd10) ? 4'd0 : r_rcount + 4'd1;
                end
                S_DEC: begin
                    r_data <= w_round;
                    if (r_rcount != 4'd0) r_rcount <= r_rcount - 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dec_iter.sv
// Self-checking bench for aes_dec_iter using FIPS-197 / SP800-38A AES-128 vectors.
module tb_aes_dec_iter;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C3 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C4 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] P4 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] KEY;
    logic         key_load;
    logic         key_ready;
    logic [127:0] IN;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] OUT;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   dbg_state;

    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];
    int           acc_q[$];
    bit           mon_en = 1'b0;
    logic         prev_valid = 1'b0;
    logic [127:0] prev_out = '0;
    int           acc_c;

    aes_dec_iter #(.BLOCK_LENGTH(128)) dut (
        .clk(clk), .rst(rst), .KEY(KEY), .key_load(key_load), .key_ready(key_ready),
        .IN(IN), .in_valid(in_valid), .in_ready(in_ready), .OUT(OUT),
        .out_valid(out_valid), .out_ready(out_ready), .o_dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load a key; optionally keep key_load/in_valid asserted with junk during expansion,
    // or raise in_valid in the same cycle as key_load.
    task automatic load_key(input logic [127:0] k, input int hold, input bit with_in);
        int n;
        KEY      = k;
        key_load = 1'b1;
        if (with_in) begin
            IN       = rnd128();
            in_valid = 1'b1;
            #1;
            check_val("in_ready_vs_key_load", 128'(in_ready), 128'd0);
        end
        tick();
        check_val("key_ready_drop", 128'(key_ready), 128'd0);
        in_valid = 1'b0;
        n = 0;
        if (hold > 0) begin
            KEY      = ~k;
            IN       = rnd128();
            in_valid = 1'b1;
            repeat (hold) begin
                tick();
                n++;
                check_val("in_ready_keyexp", 128'(in_ready), 128'd0);
            end
            in_valid = 1'b0;
        end
        key_load = 1'b0;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        check_val("key_latency", 128'(n), 128'd10);
    endtask

    task automatic send_block(input logic [127:0] ct, input logic [127:0] pt);
        int n;
        n        = 0;
        IN       = ct;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check_val("accept_timeout", 128'(n < 100), 128'd1);
        exp_q.push_back(pt);
        tick();
        acc_q.push_back(cyc);
        in_valid = 1'b0;
        IN       = rnd128();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check_val("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    // scoreboard: latency on out_valid rise, stability while held, data on handshake
    always @(negedge clk) begin
        if (mon_en) begin
            if (!out_valid) begin
                check_val("out_zero", OUT, 128'd0);
            end else begin
                if (!prev_valid) begin
                    if (acc_q.size() == 0) begin
                        check_val("unexp_valid", 128'd1, 128'd0);
                    end else begin
                        acc_c = acc_q.pop_front();
                        check_val("latency", 128'(cyc - acc_c), 128'd10);
                    end
                end else begin
                    check_val("out_stable", OUT, prev_out);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) check_val("unexp_out", 128'd1, 128'd0);
                    else                   check_val("plaintext", OUT, exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_out   = OUT;
        end
    end

    initial begin
        int n;
        rst       = 1'b0;
        KEY       = '0;
        key_load  = 1'b0;
        IN        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_val("rst_key_ready", 128'(key_ready), 128'd0);
        check_val("rst_in_ready", 128'(in_ready), 128'd0);
        check_val("rst_out_valid", 128'(out_valid), 128'd0);
        check_val("rst_out", OUT, 128'd0);
        check_val("rst_state", 128'(dbg_state), 128'd0);
        rst    = 1'b1;
        mon_en = 1'b1;

        // no key yet: in_valid must be ignored
        IN       = C1;
        in_valid = 1'b1;
        repeat (3) begin
            tick();
            check_val("nokey_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;

        // FIPS-197 vector
        load_key(K1, 0, 1'b0);
        send_block(C1, P1);
        wait_idle();

        // key reload with key_load/in_valid held during expansion
        load_key(K2, int'($urandom_range(2, 7)), 1'b0);
        send_block(C2, P2);
        wait_idle();

        // backpressure, plus key_load/in_valid during DEC
        out_ready = 1'b0;
        send_block(C3, P3);
        KEY      = K1;
        key_load = 1'b1;
        IN       = C1;
        in_valid = 1'b1;
        repeat (4) begin
            tick();
            check_val("dec_in_ready", 128'(in_ready), 128'd0);
            check_val("dec_key_ready", 128'(key_ready), 128'd1);
        end
        key_load = 1'b0;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            tick();
            n++;
        end
        check_val("hold_reached", 128'(out_valid), 128'd1);
        repeat (5) begin
            tick();
            check_val("hold_valid", 128'(out_valid), 128'd1);
            check_val("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        check_val("ready_after_hold", 128'(in_ready), 128'd1);
        check_val("valid_after_hold", 128'(out_valid), 128'd0);
        send_block(C4, P4);
        send_block(C3, P3);
        wait_idle();

        // key_load and in_valid together in READY: reload wins
        load_key(K1, 0, 1'b1);
        send_block(C1, P1);
        wait_idle();

        // reset during DEC round 5 discards block and key
        send_block(C1, P1);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        check_val("abort_key_ready", 128'(key_ready), 128'd0);
        check_val("abort_in_ready", 128'(in_ready), 128'd0);
        check_val("abort_out_valid", 128'(out_valid), 128'd0);
        check_val("abort_out", OUT, 128'd0);
        check_val("abort_state", 128'(dbg_state), 128'd0);
        IN       = C1;
        in_valid = 1'b1;
        repeat (12) begin
            tick();
            check_val("abort_in_ignored", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        load_key(K2, 0, 1'b0);
        send_block(C2, P2);
        wait_idle();

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_dec_iter.md
AES_DEC_ITER -- requirements
Module: aes_dec_iter

Interface
REQ-001 Parameter: BLOCK_LENGTH, default 128, data/key width; only 128 is supported (AES-128).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 KEY  input  128  cipher key, sampled on an accepted key_load.
REQ-005 key_load  input  1  request to load KEY and expand round keys.
REQ-006 key_ready  output  1  round keys valid; block may accept ciphertext.
REQ-007 IN  input  128  ciphertext block, byte 0 in IN[127:120].
REQ-008 in_valid  input  1  IN is valid.
REQ-009 in_ready  output  1  block can accept IN this cycle.
REQ-010 OUT  output  128  plaintext block, same byte order as IN.
REQ-011 out_valid  output  1  OUT holds a finished plaintext.
REQ-012 out_ready  input  1  downstream accepts OUT.

Function
REQ-013 Datapath SHALL be iterative: one round per cycle, one round-key register file rk[0..10] of 128 bits each, with forward and inverse S-box leaf lookups.
REQ-014 FSM states: NOKEY, KEYEXP, READY, DEC, HOLD.
REQ-015 NOKEY: key_ready=0, in_ready=0; key_load=1 -> rk[0]<=KEY, rcount<=1, go KEYEXP.
REQ-016 KEYEXP: each cycle rk[rcount]<=FIPS-197 expansion of rk[rcount-1] with Rcon[rcount]; after rk[10] is written, go READY. This takes exactly 10 cycles. key_load is ignored in KEYEXP.
REQ-017 READY: key_ready=1, in_ready=!key_load.
  - key_load=1 -> re-enter key load as in NOKEY; key_load takes priority over in_valid.
  - in_valid&&in_ready -> state<=IN^rk[10], rcount<=9, go DEC.
REQ-018 DEC, rcount 9..1: state<=InvMixColumns(InvSubBytes(InvShiftRows(state))^rk[rcount]); rcount decrements.
REQ-019 DEC, rcount 0: state<=InvSubBytes(InvShiftRows(state))^rk[0], with no InvMixColumns; go HOLD.
REQ-020 Latency: out_valid SHALL rise exactly 10 clock edges after the accepting edge (11 cycles total occupancy before HOLD).
REQ-021 HOLD: out_valid=1, OUT=state, held stable until out_ready=1; on that edge go READY.
  - Next block can be accepted no earlier than the cycle after the out handshake.
REQ-022 OUT SHALL be 128'b0 whenever out_valid=0.
REQ-023 in_ready=0 and key_load is ignored in DEC and HOLD; round keys are never modified mid-block.
REQ-024 key_ready stays 1 through DEC and HOLD and drops to 0 on the edge that accepts key_load.

Reset
REQ-025 rst=0 at a clock edge: state NOKEY; rk[0..10], state register and rcount cleared. Outputs key_ready=0, in_ready=0, out_valid=0, OUT=0.
REQ-026 Reset asserted mid-KEYEXP, mid-DEC or in HOLD SHALL abort the operation, discard the result and the key, and require a new key_load.

Verification
REQ-027 Key 000102030405060708090a0b0c0d0e0f loaded, IN 69c4e0d86a7b0430d8cdb78070b4c55a -> OUT 00112233445566778899aabbccddeeff, out_valid exactly 10 edges after acceptance.
REQ-028 Key 2b7e151628aed2a6abf7158809cf4f3c, IN 3925841d02dc09fbdc118597196a0b32 -> OUT 3243f6a8885a308d313198a2e0370734; key_ready rises 10 cycles after key_load.
REQ-029 Backpressure: out_ready=0 for 5 cycles in HOLD -> OUT/out_valid stable, in_ready=0; out_ready=1 -> READY the next cycle, and back-to-back blocks decrypt correctly.
REQ-030 key_load and in_valid high together in READY -> block not accepted, key reloaded; new-key ciphertext then decrypts correctly.
REQ-031 rst=0 during DEC round 5 -> all outputs 0 next cycle; in_valid is ignored until key_load completes.
REQ-032 in_valid and key_load held high in NOKEY/KEYEXP and during DEC -> no acceptance and no key change.
